floor_input_conditioner: RTL and testbench
==========================================

# floor_input_conditioner

Conditions the six raw freight-elevator inputs (call buttons P1–P3 and floor endstops Fc1–Fc3) before they reach the cabin state machine. Each pin is synchronised, debounced and registered; button presses are latched into pending floor requests that clear when the cabin reaches that floor. Sits directly upstream of `fsm` inside `montacargas`: its `button` and `endstop` outputs drive `fsm.button` and `fsm.endstop`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples required before a debounced level changes (10 ms at 50 MHz); must be ≥ 2.
- `CNT_W`, default 19: counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `clk`, input, 1: system clock; all state on rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `btn_raw`, input, 3: raw buttons {P3,P2,P1}, active-high, asynchronous to `clk`.
- `fc_raw`, input, 3: raw endstops {Fc3,Fc2,Fc1}, active-high, asynchronous to `clk`.
- `button`, output, 3: pending-request vector (latched mode) or debounced button levels (level mode) → `fsm.button`.
- `endstop`, output, 3: debounced endstop levels → `fsm.endstop`.
- `fault`, output, 1: registered flag, high while more than one debounced endstop is high.

## Operation
- Reset (`rst`=0, asynchronous): sync flops, debounced levels, counters, request latches and `fault` are all 0, so `button`=0, `endstop`=0 and `fault`=0. Release is taken on the next `clk` edge.
- Synchroniser: two flops per channel (6 channels). `s` is the second-stage value.
- Debounce, per channel, with state `stable` and `cnt`:
  - If `s` == `stable`: `cnt` ← 0.
  - Else if `cnt` == DEBOUNCE_CYCLES−1: `stable` ← `s`, `cnt` ← 0.
  - Else: `cnt` ← `cnt`+1.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes `stable`. The counter restarts on any bounce back to `stable`.
- `endstop` = debounced endstop `stable` bits.
- Request latch, per floor i, with `prev_i` = last cycle's debounced button:
  - `set_i` = debounced button rising edge (stable_i & ~prev_i).
  - `clr_i` = debounced endstop_i high.
  - `req_i` ← 0 if `clr_i`; else 1 if `set_i`; else hold. Clear wins, so a press at the current floor is ignored.
  - Any combination of the three requests may be pending at once; no priority is applied here, the FSM arbitrates.
  - Holding a button produces exactly one set.
- `fault` ← (popcount(debounced endstop) ≥ 2), registered. Outputs are not suppressed while `fault` is high.

## Timing
- Pin change to debounced `stable`: 2 sync edges + DEBOUNCE_CYCLES edges. With DEBOUNCE_CYCLES=4, `stable` rises on the 6th rising edge after the pin first samples high.
- `endstop` changes in the same cycle as its `stable`.
- `req_i` sets 1 cycle after the debounced button rises and clears 1 cycle after the debounced endstop rises.
- `fault` lags the debounced endstops by 1 cycle.
- Reset asserted mid-count discards counts and pending requests immediately, with no wait for a clock edge.

## Configuration
- `REQ_LATCH_EN` defined: `button` = `req[2:0]` (latched requests, clear-on-arrival as described above).
- `REQ_LATCH_EN` undefined: request latches and edge detectors are not compiled; `button` = debounced button levels, so the FSM sees a press only while it is held. `endstop` and `fault` are identical in both builds.

## Structure
- Shared package `montacargas_pkg`:
  - `N_FLOORS` = 3.
  - Default `DEBOUNCE_CYCLES`.
  - Floor index constants `FLOOR_1..FLOOR_3`. These are reused by `fsm`.
- One sub-module, `debounce`: 1-bit two-flop synchroniser plus stability counter, parameterised by `DEBOUNCE_CYCLES`/`CNT_W`, instantiated 6 times. Latch, edge-detect and fault logic stay in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, CNT_W=3, with `REQ_LATCH_EN` defined unless stated otherwise.
- Reset: hold `rst`=0 with all raw inputs =1 → `button`=0, `endstop`=0, `fault`=0 throughout; after release, `endstop`=3'b111 after 6 edges and `fault`=1 one edge later.
- Bounce: P2 pulses high 1, 2 then 3 cycles with low gaps, then holds high → `button` stays 0 through the pulses; `button`=3'b010 exactly 7 edges after the final rising sample.
- Clear-on-arrival: latch P3 (`button`=3'b100), then raise Fc3 → `button`=3'b000 one cycle after `endstop`=3'b100.
- Press at current floor: Fc1 debounced high, press P1 → `button[0]` never asserts. Press P2 and P3 together → `button`=3'b110.
- Reset mid-count: P1 high for 3 samples past sync, pulse `rst` low asynchronously → count discarded; after release P1 needs a full 6 edges again.
- `REQ_LATCH_EN` undefined: press and release P2 → `button[1]` high only while the debounced level is high, and returns to 0 with no latch.

Source files
------------

// File: rtl/floor_input_conditioner_pkg.sv
// Shared constants for the freight-elevator (montacargas) blocks.
// Floor indices are reused by the cabin FSM.
package montacargas_pkg;

  localparam int N_FLOORS                = 3;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int CNT_W_DEFAULT           = 19;

  localparam int FLOOR_1 = 0;
  localparam int FLOOR_2 = 1;
  localparam int FLOOR_3 = 2;

  // Number of floors whose bit is set in a floor vector
  function automatic logic [1:0] popcount3(input logic [N_FLOORS-1:0] v);
    popcount3 = {1'b0, v[FLOOR_1]} + {1'b0, v[FLOOR_2]} + {1'b0, v[FLOOR_3]};
  endfunction

endpackage

// File: rtl/floor_input_conditioner_if.sv
// Raw elevator pins in, conditioned floor vectors out.
// master = pin/FSM side, slave = floor_input_conditioner.
interface floor_input_conditioner_if;
  import montacargas_pkg::*;

  logic [N_FLOORS-1:0] btn_raw;
  logic [N_FLOORS-1:0] fc_raw;
  logic [N_FLOORS-1:0] button;
  logic [N_FLOORS-1:0] endstop;
  logic                fault;

  modport master (
    output btn_raw,
    output fc_raw,
    input  button,
    input  endstop,
    input  fault
  );

  modport slave (
    input  btn_raw,
    input  fc_raw,
    output button,
    output endstop,
    output fault
  );

endinterface

// File: rtl/floor_input_conditioner_debounce.sv
// One channel: two-flop synchroniser followed by a stability counter.
// o_stable only changes after DEBOUNCE_CYCLES consecutive differing samples.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // Synchroniser and stability counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= {CNT_W{1'b0}};
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_cnt    <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/floor_input_conditioner.sv
// Conditions elevator buttons/endstops for the cabin FSM.
// Define REQ_LATCH_EN to latch presses as pending requests (clear-on-arrival).
module floor_input_conditioner
  import montacargas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  floor_input_conditioner_if.slave  bus
);

  logic [2*N_FLOORS-1:0] w_raw;
  logic [2*N_FLOORS-1:0] w_stable;
  logic [N_FLOORS-1:0]   w_btn_db;
  logic [N_FLOORS-1:0]   w_fc_db;
  logic                  r_fault;

  assign w_raw = {bus.fc_raw, bus.btn_raw};

  for (genvar g = 0; g < 2*N_FLOORS; g++) begin : g_db
    debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .i_clk    (clk),
      .i_rst_n  (rst),
      .i_raw    (w_raw[g]),
      .o_stable (w_stable[g])
    );
  end

  assign w_btn_db    = w_stable[N_FLOORS-1:0];
  assign w_fc_db     = w_stable[2*N_FLOORS-1:N_FLOORS];
  assign bus.endstop = w_fc_db;
  assign bus.fault   = r_fault;

  // Cabin cannot be at two floors at once: flag overlapping endstops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= (popcount3(w_fc_db) >= 2'd2);
    end
  end

`ifdef REQ_LATCH_EN
  logic [N_FLOORS-1:0] r_prev;
  logic [N_FLOORS-1:0] r_req;

  // Request latches; arrival at a floor overrides a press there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= {N_FLOORS{1'b0}};
      r_req  <= {N_FLOORS{1'b0}};
    end else begin
      r_prev <= w_btn_db;
      for (int i = 0; i < N_FLOORS; i++) begin
        if (w_fc_db[i]) begin
          r_req[i] <= 1'b0;
        end else if (w_btn_db[i] && !r_prev[i]) begin
          r_req[i] <= 1'b1;
        end else begin
          r_req[i] <= r_req[i];
        end
      end
    end
  end

  assign bus.button = r_req;
`else
  assign bus.button = w_btn_db;
`endif

endmodule

// File: tb/tb_floor_input_conditioner.sv
// Directed bench for floor_input_conditioner with DEBOUNCE_CYCLES=4, CNT_W=3.
// Expectations cover both builds of REQ_LATCH_EN.
module tb_floor_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  floor_input_conditioner_if bus ();

  floor_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btn;
    logic [2:0] fc;
    int         edges;
    logic [2:0] exp_latch;
    logic [2:0] exp_level;
    logic [2:0] exp_end;
    logic       exp_fault;
  } vec_t;

  vec_t vecs [14];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  function automatic logic [2:0] pick(input logic [2:0] latch_v, input logic [2:0] level_v);
`ifdef REQ_LATCH_EN
    return latch_v;
`else
    return level_v;
`endif
  endfunction

  task automatic check_all(input string name, input logic [2:0] b, input logic [2:0] e, input logic f);
    check({name, ".button"},  bus.button,  b);
    check({name, ".endstop"}, bus.endstop, e);
    check({name, ".fault"},   {2'b00, bus.fault}, {2'b00, f});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.btn_raw = 3'b000;
    bus.fc_raw  = 3'b000;
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    //                btn     fc      n  latch   level   end     fault
    vecs[0]  = '{3'b000, 3'b000, 2, 3'b000, 3'b000, 3'b000, 1'b0};
    vecs[1]  = '{3'b100, 3'b000, 5, 3'b000, 3'b000, 3'b000, 1'b0};
    vecs[2]  = '{3'b100, 3'b000, 1, 3'b000, 3'b100, 3'b000, 1'b0};
    vecs[3]  = '{3'b100, 3'b000, 1, 3'b100, 3'b100, 3'b000, 1'b0};
    vecs[4]  = '{3'b000, 3'b000, 6, 3'b100, 3'b000, 3'b000, 1'b0};
    vecs[5]  = '{3'b000, 3'b100, 6, 3'b100, 3'b000, 3'b100, 1'b0};
    vecs[6]  = '{3'b000, 3'b100, 1, 3'b000, 3'b000, 3'b100, 1'b0};
    vecs[7]  = '{3'b000, 3'b001, 6, 3'b000, 3'b000, 3'b001, 1'b0};
    vecs[8]  = '{3'b001, 3'b001, 7, 3'b000, 3'b001, 3'b001, 1'b0};
    vecs[9]  = '{3'b111, 3'b001, 7, 3'b110, 3'b111, 3'b001, 1'b0};
    vecs[10] = '{3'b000, 3'b011, 6, 3'b110, 3'b000, 3'b011, 1'b0};
    vecs[11] = '{3'b000, 3'b011, 1, 3'b100, 3'b000, 3'b011, 1'b1};
    vecs[12] = '{3'b000, 3'b000, 6, 3'b100, 3'b000, 3'b000, 1'b1};
    vecs[13] = '{3'b000, 3'b000, 1, 3'b100, 3'b000, 3'b000, 1'b0};

    // Reset held with every raw pin high
    rst = 1'b0;
    bus.btn_raw = 3'b111;
    bus.fc_raw  = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_all("rst_hold", 3'b000, 3'b000, 1'b0);
    end
    #2 rst = 1'b1;
    step(5);
    check_all("rst_rel5", 3'b000, 3'b000, 1'b0);
    step(1);
    check_all("rst_rel6", pick(3'b000, 3'b111), 3'b111, 1'b0);
    step(1);
    check_all("rst_rel7", pick(3'b000, 3'b111), 3'b111, 1'b1);

    // Bounce on P2: pulses of 1, 2, 3 samples, then a hold
    do_reset();
    for (int p = 1; p <= 3; p++) begin
      bus.btn_raw = 3'b010;
      for (int k = 0; k < p; k++) begin
        step(1);
        check("bounce_hi", bus.button, 3'b000);
      end
      bus.btn_raw = 3'b000;
      for (int k = 0; k < 2; k++) begin
        step(1);
        check("bounce_lo", bus.button, 3'b000);
      end
    end
    bus.btn_raw = 3'b010;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("bounce_hold", bus.button, 3'b000);
    end
    step(1);
    check("bounce_e6", bus.button, pick(3'b000, 3'b010));
    step(1);
    check("bounce_e7", bus.button, 3'b010);

    // Main vector table: latch, clear-on-arrival, press at current floor, fault
    do_reset();
    for (int v = 0; v < 14; v++) begin
      bus.btn_raw = vecs[v].btn;
      bus.fc_raw  = vecs[v].fc;
      step(vecs[v].edges);
      check_all($sformatf("vec%0d", v), pick(vecs[v].exp_latch, vecs[v].exp_level),
                vecs[v].exp_end, vecs[v].exp_fault);
    end

    // Async reset mid-count drops the pending request and the partial count
    bus.btn_raw = 3'b001;
    step(5);
    check("mid_pre", bus.button, pick(3'b100, 3'b000));
    #2 rst = 1'b0;
    #1;
    check("mid_async", bus.button, 3'b000);
    #2 rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("mid_recount", bus.button, 3'b000);
    end
    step(1);
    check("mid_e6", bus.button, pick(3'b000, 3'b001));
    step(1);
    check("mid_e7", bus.button, 3'b001);

    // Release P1: level build returns to 0, latch build holds the request
    bus.btn_raw = 3'b000;
    step(6);
    check("release", bus.button, pick(3'b001, 3'b000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
